disparity_min_buffer: RTL and testbench

DISPARITY_MIN_BUFFER -- requirements
Module: disparity_min_buffer

---
 rtl/disparity_min_buffer.sv | 139 +++++++++++++
 tb/tb_disparity_min_buffer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/disparity_min_buffer.sv
// rtl/disparity_min_buffer.sv - circular min-cost buffer with fill/merge/drain passes
// Optional DISP_TIE_NEWER_EN: cost ties take the incoming (higher disparity) word.
module disparity_min_buffer #(
  parameter int DATA_W = 20,
  parameter int COST_W = 14,
  parameter int ADDR_W = 9
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [5:0]        disparity,
  output logic              in_ready,
  input  logic              out_read,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              pass_done,
  output logic              overflow_err,
  output logic              underflow_err
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {FILL, MERGE, DRAIN} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   rd_ptr, wr_ptr;
  logic [ADDR_W:0]     merge_cnt;
  logic                do_push, do_pop, do_merge, set_ovf, set_unf;
  logic                take_new;
  logic [DATA_W-1:0]   head, merge_word;

  assign head      = mem[rd_ptr];
  assign out_data  = head;
  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign out_valid = !empty;

`ifdef DISP_TIE_NEWER_EN
  assign take_new = (in_data[COST_W-1:0] <= head[COST_W-1:0]);
`else
  assign take_new = (in_data[COST_W-1:0] < head[COST_W-1:0]);
`endif
  assign merge_word = take_new ? in_data : head;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    do_merge  = 1'b0;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    case (state)
      FILL, MERGE: begin
        // In MERGE a first-pass word is only taken once the buffer is empty (new line)
        if (disparity == 6'd0) in_ready = (state == FILL) ? !full : empty;
        else                   in_ready = !empty;
        if (in_valid) begin
          if (disparity == 6'd0) begin
            if (full) set_ovf = 1'b1;
            else if (in_ready) begin
              do_push   = 1'b1;
              state_nxt = FILL;
            end
          end else if (empty) begin
            set_unf = 1'b1;
          end else begin
            do_merge  = 1'b1;
            state_nxt = MERGE;
          end
        end else if (out_read && !empty) begin
          do_pop    = 1'b1;
          state_nxt = (count == ONE_CNT) ? FILL : DRAIN;
        end
      end
      DRAIN: begin
        if (out_read && !empty) begin
          do_pop = 1'b1;
          if (count == ONE_CNT) state_nxt = FILL;
        end else if (empty) begin
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= FILL;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      merge_cnt     <= '0;
      pass_done     <= 1'b0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      pass_done <= 1'b0;
      if (set_ovf) overflow_err  <= 1'b1;
      if (set_unf) underflow_err <= 1'b1;
      if (do_push) begin
        wr_ptr    <= wr_ptr + ADDR_W'(1);
        count     <= count + ONE_CNT;
        merge_cnt <= '0;
      end
      if (do_pop) begin
        rd_ptr    <= rd_ptr + ADDR_W'(1);
        count     <= count - ONE_CNT;
        merge_cnt <= '0;
      end
      // A merge rotates the ring: head out, winner in at the tail
      if (do_merge) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
        wr_ptr <= wr_ptr + ADDR_W'(1);
        if (merge_cnt + ONE_CNT == count) begin
          merge_cnt <= '0;
          pass_done <= 1'b1;
        end else begin
          merge_cnt <= merge_cnt + ONE_CNT;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (do_push)       mem[wr_ptr] <= in_data;
    else if (do_merge) mem[wr_ptr] <= merge_word;
  end

endmodule

// File: tb/tb_disparity_min_buffer.sv
// tb/tb_disparity_min_buffer.sv - directed self-checking bench for disparity_min_buffer
module tb_disparity_min_buffer;
  localparam int DATA_W = 20;
  localparam int COST_W = 14;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 512;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [5:0]        disparity;
  logic              in_ready;
  logic              out_read;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              pass_done;
  logic              overflow_err;
  logic              underflow_err;

  int checks   = 0;
  int failures = 0;

  disparity_min_buffer #(.DATA_W(DATA_W), .COST_W(COST_W), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .disparity(disparity), .in_ready(in_ready), .out_read(out_read),
    .out_valid(out_valid), .out_data(out_data), .empty(empty), .full(full),
    .count(count), .pass_done(pass_done), .overflow_err(overflow_err),
    .underflow_err(underflow_err)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] word(input logic [5:0] d, input int c);
    return {d, COST_W'(c)};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    out_read  = 1'b0;
    disparity = 6'd0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic cand(input logic [5:0] d, input int c);
    in_valid  = 1'b1;
    disparity = d;
    in_data   = word(d, c);
    tick();
    idle();
  endtask

  logic [DATA_W-1:0] drain_exp [4];

  initial begin
    idle();
    in_data = '0;
    reset   = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    check_eq("rst_empty", empty, 1);
    check_eq("rst_full", full, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_count", count, 0);
    check_eq("rst_errs", {overflow_err, underflow_err, pass_done}, 0);

    // nonzero disparity on an empty buffer
    in_valid  = 1'b1;
    disparity = 6'd3;
    in_data   = word(3, 7);
    #1;
    check_eq("unf_in_ready", in_ready, 0);
    tick();
    idle();
    check_eq("unf_flag", underflow_err, 1);
    check_eq("unf_count", count, 0);
    do_reset();
    check_eq("unf_cleared", underflow_err, 0);

    // first pass fill
    cand(0, 10); cand(0, 20); cand(0, 30); cand(0, 40);
    check_eq("fill_count", count, 4);
    check_eq("fill_in_ready", in_ready, 1);
    check_eq("fill_head", out_data, word(0, 10));

    // merge pass: the 30/30 tie keeps the stored disparity-0 word
    cand(1, 5); cand(1, 25); cand(1, 30);
    check_eq("merge_pd_early", pass_done, 0);
    cand(1, 1);
    check_eq("merge_pd", pass_done, 1);
    check_eq("merge_count", count, 4);
    tick();
    check_eq("merge_pd_clear", pass_done, 0);

    drain_exp[0] = word(1, 5);
    drain_exp[1] = word(0, 20);
    drain_exp[2] = word(0, 30);
    drain_exp[3] = word(1, 1);
    out_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("drain_%0d", i), out_data, drain_exp[i]);
      tick();
    end
    out_read = 1'b0;
    check_eq("drain_empty", empty, 1);
    check_eq("drain_count", count, 0);
    check_eq("drain_back_fill", in_ready, 1);

    // push wins over out_read outside DRAIN
    cand(0, 50);
    in_valid = 1'b1;
    out_read = 1'b1;
    in_data  = word(0, 60);
    tick();
    idle();
    check_eq("both_count", count, 2);
    check_eq("both_head", out_data, word(0, 50));

    // overflow
    do_reset();
    for (int i = 0; i < DEPTH; i++) cand(0, 100 + i);
    check_eq("ovf_full", full, 1);
    check_eq("ovf_in_ready", in_ready, 0);
    cand(0, 999);
    check_eq("ovf_flag", overflow_err, 1);
    check_eq("ovf_count", count, DEPTH);
    check_eq("ovf_head", out_data, word(0, 100));

    // reset mid-merge after two merged words
    cand(2, 50);
    cand(2, 500);
    check_eq("mid_head", out_data, word(0, 102));
    check_eq("mid_count", count, DEPTH);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mid_rst_count", count, 0);
    check_eq("mid_rst_pd", pass_done, 0);
    check_eq("mid_rst_errs", {overflow_err, underflow_err}, 0);
    check_eq("mid_rst_empty", empty, 1);
    check_eq("mid_rst_out_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
